uart_mmio_responder: RTL and testbench

//  Bus-side responder for the memory-mapped UART. Decodes core load/store accesses
//  (address/write_data/write_mask/write_enable/read_enable), buffers TX bytes and RX bytes
//  in FIFOs and drives the Uart serial engine via a start/busy handshake. Sits between Core
//  and Uart in Top; hit gates the DMemory write enable and the read_data mux.

---
 rtl/uart_mmio_responder_if.sv | 21 ++
 rtl/uart_mmio_responder.sv | 149 ++++++++++++++
 tb/tb_uart_mmio_responder.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_responder_if.sv
// Core load/store port of the memory-mapped UART responder.
// The core drives the access; the responder answers with read data and an address hit.
interface uart_mmio_responder_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output address, write_data, write_mask, write_enable, read_enable,
    input  read_data, hit
  );

  modport slave (
    input  address, write_data, write_mask, write_enable, read_enable,
    output read_data, hit
  );
endinterface

// File: rtl/uart_mmio_responder.sv
// Bus-side UART responder: decodes DATA/STATUS/BAUD, buffers TX and RX bytes in FIFOs
// and hands TX bytes to the serial engine through a start/busy handshake.
module uart_mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned RX_DEPTH  = 4,
  parameter logic [15:0] BAUD_RST  = 16'h0003
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_mmio_responder_if.slave  bus,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [15:0]           baud_max
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam logic [TxAw:0] TxOne = 1;
  localparam logic [RxAw:0] RxOne = 1;

  localparam logic [31:0] DataAddr   = BASE_ADDR;
  localparam logic [31:0] StatusAddr = BASE_ADDR + 32'h0000_0005;
  localparam logic [31:0] BaudAddr   = BASE_ADDR + 32'h0000_0100;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitBusy, StWaitDone} tx_state_e;

  tx_state_e state_q;

  logic [7:0]  tx_mem_q [TX_DEPTH];
  logic [7:0]  rx_mem_q [RX_DEPTH];
  logic [TxAw:0] tx_wptr_q, tx_rptr_q;
  logic [RxAw:0] rx_wptr_q, rx_rptr_q;
  logic        rx_ovr_q;

  logic sel_data, sel_status, sel_baud;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic ovr_set, ovr_clr, tx_active;
  logic [7:0] status;
  logic unused_bits;

  assign sel_data   = (bus.address == DataAddr);
  assign sel_status = (bus.address == StatusAddr);
  assign sel_baud   = (bus.address == BaudAddr);
  assign bus.hit    = sel_data | sel_status | sel_baud;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TxAw] != tx_rptr_q[TxAw]) &&
                    (tx_wptr_q[TxAw-1:0] == tx_rptr_q[TxAw-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RxAw] != rx_rptr_q[RxAw]) &&
                    (rx_wptr_q[RxAw-1:0] == rx_rptr_q[RxAw-1:0]);

  // A push into a full TX FIFO is still taken when the FSM pops on the same edge.
  assign tx_pop  = (state_q == StLoad) & ~tx_empty;
  assign tx_push = bus.write_enable & sel_data & bus.write_mask[0] & (~tx_full | tx_pop);
  assign rx_pop  = bus.read_enable & sel_data & ~rx_empty;
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  assign ovr_set = rx_valid & rx_full & ~rx_pop;
  assign ovr_clr = bus.read_enable & sel_status;

  assign tx_active = ~tx_empty | (state_q != StIdle) | tx_busy;
  assign status    = {1'b0, tx_active, tx_full, 3'b000, rx_ovr_q, ~rx_empty};

  always_comb begin
    bus.read_data = 32'h0;
    if (sel_data && !rx_empty) begin
      bus.read_data = {24'h0, rx_mem_q[rx_rptr_q[RxAw-1:0]]};
    end else if (sel_status) begin
      bus.read_data = {24'h0, status};
    end else if (sel_baud) begin
      bus.read_data = {16'h0, baud_max};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + TxOne;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxOne;
      if (rx_push) rx_wptr_q <= rx_wptr_q + RxOne;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + RxOne;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[TxAw-1:0]] <= bus.write_data[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q[RxAw-1:0]] <= rx_data;
  end

  // Overrun set wins over a same-cycle STATUS read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovr_q <= 1'b0;
    end else if (ovr_set) begin
      rx_ovr_q <= 1'b1;
    end else if (ovr_clr) begin
      rx_ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_max <= BAUD_RST;
    end else if (bus.write_enable && sel_baud) begin
      if (bus.write_mask[0]) baud_max[7:0]  <= bus.write_data[7:0];
      if (bus.write_mask[1]) baud_max[15:8] <= bus.write_data[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!tx_empty && !tx_busy) state_q <= StLoad;
        end
        StLoad: begin
          tx_data  <= tx_mem_q[tx_rptr_q[TxAw-1:0]];
          tx_start <= 1'b1;
          state_q  <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_busy) state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (!tx_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign unused_bits = ^{bus.write_data[31:16], bus.write_mask[3:2]};

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder: constant vector table, directed TX/RX
// corner sequences and random traffic against a queue-based reference model.
module tb_uart_mmio_responder;

  localparam logic [31:0] Base = 32'h1001_0000;
  localparam logic [31:0] DataA = Base;
  localparam logic [31:0] StatA = Base + 32'h5;
  localparam logic [31:0] BaudA = Base + 32'h100;
  localparam logic [31:0] NoneA = Base + 32'h200;
  localparam int TxD = 4;
  localparam int RxD = 4;
  localparam int BusyLen = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] baud_max;

  uart_mmio_responder_if bus ();

  uart_mmio_responder #(
    .BASE_ADDR (Base),
    .TX_DEPTH  (TxD),
    .RX_DEPTH  (RxD),
    .BAUD_RST  (16'h0003)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_max (baud_max)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_ovr;
  logic [15:0] m_baud;
  logic        pend_push;
  logic [7:0]  pend_byte;
  int          busy_cnt;
  logic        hold;
  logic        busy_h1, busy_h2;
  int          starts;
  int          n_checks;
  int          n_fails;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        we;
    logic        re;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs at a negedge: accounts for what the previous posedge did on the TX side
  // and models the Uart (busy for BusyLen cycles after each start).
  task automatic observe();
    int sz;
    bit popped;
    busy_h2 = busy_h1;
    busy_h1 = tx_busy;
    popped  = (tx_start === 1'b1);
    sz      = tx_q.size();
    if (popped) begin
      starts++;
      check("start_needs_idle_uart", {31'b0, busy_h2}, 32'h0);
      if (sz == 0) begin
        check("start_without_byte", {31'b0, tx_start}, 32'h0);
      end else begin
        check("tx_data", {24'b0, tx_data}, {24'b0, tx_q[0]});
        void'(tx_q.pop_front());
      end
      busy_cnt = BusyLen;
    end
    if (pend_push) begin
      if (sz < TxD || popped) tx_q.push_back(pend_byte);
      pend_push = 1'b0;
    end
    tx_busy = hold || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                      input logic we, input logic re, input logic rxv, input logic [7:0] rxd,
                      output logic [31:0] rd, output logic h);
    logic [31:0] exp_rd, cmp_mask;
    logic exp_hit;
    bit rx_was_full, rx_popped;
    observe();
    bus.address      = a;
    bus.write_data   = wd;
    bus.write_mask   = wm;
    bus.write_enable = we;
    bus.read_enable  = re;
    rx_valid         = rxv;
    rx_data          = rxd;
    #1;
    exp_hit  = 1'b0;
    exp_rd   = 32'h0;
    cmp_mask = 32'hFFFF_FFFF;
    if (a == DataA) begin
      exp_hit = 1'b1;
      if (rx_q.size() != 0) exp_rd = {24'b0, rx_q[0]};
    end else if (a == StatA) begin
      exp_hit  = 1'b1;
      exp_rd   = {24'b0, 1'b0, 1'b0, tx_q.size() == TxD, 3'b0, m_ovr, rx_q.size() != 0};
      cmp_mask = 32'hFFFF_FFBF; // tx_active checked only at quiet points
    end else if (a == BaudA) begin
      exp_hit = 1'b1;
      exp_rd  = {16'b0, m_baud};
    end
    rd = bus.read_data;
    h  = bus.hit;
    check("hit", {31'b0, h}, {31'b0, exp_hit});
    check("read_data", rd & cmp_mask, exp_rd);
    check("baud_max", {16'b0, baud_max}, {16'b0, m_baud});
    if (we && a == DataA && wm[0]) begin
      pend_push = 1'b1;
      pend_byte = wd[7:0];
    end
    if (we && a == BaudA) begin
      if (wm[0]) m_baud[7:0]  = wd[7:0];
      if (wm[1]) m_baud[15:8] = wd[15:8];
    end
    rx_was_full = (rx_q.size() == RxD);
    rx_popped   = 1'b0;
    if (re && a == DataA && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      rx_popped = 1'b1;
    end
    if (re && a == StatA) m_ovr = 1'b0;
    if (rxv) begin
      if (!rx_was_full || rx_popped) rx_q.push_back(rxd);
      else m_ovr = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    logic h;
    for (int i = 0; i < n; i++) step(NoneA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
  endtask

  task automatic do_reset();
    bus.address      = NoneA;
    bus.write_data   = 32'h0;
    bus.write_mask   = 4'h0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    rx_valid         = 1'b0;
    rx_data          = 8'h0;
    rst              = 1'b1;
    for (int i = 0; i < 2; i++) begin
      observe();
      @(posedge clk);
      @(negedge clk);
    end
    tx_q.delete();
    rx_q.delete();
    m_ovr     = 1'b0;
    m_baud    = 16'h0003;
    pend_push = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((tx_q.size() != 0 || busy_cnt != 0 || pend_push || tx_busy) && k < 300) begin
      idle(1);
      k++;
    end
    check(name, {31'b0, tx_q.size() == 0 && !tx_busy}, 32'h1);
    idle(4);
  endtask

  initial begin
    logic [31:0] rd;
    logic h;
    int s0;
    n_checks = 0;
    n_fails  = 0;
    starts   = 0;
    busy_cnt = 0;
    hold     = 1'b0;
    busy_h1  = 1'b0;
    busy_h2  = 1'b0;
    tx_busy  = 1'b0;
    pend_push = 1'b0;
    pend_byte = 8'h0;
    m_ovr    = 1'b0;
    m_baud   = 16'h0003;

    tbl[0]  = '{StatA, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0,    1'b1};
    tbl[1]  = '{BaudA, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0003, 1'b1};
    tbl[2]  = '{BaudA, 32'h1234_5678, 4'h1, 1'b1, 1'b0, 32'h0003, 1'b1};
    tbl[3]  = '{BaudA, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0078, 1'b1};
    tbl[4]  = '{BaudA, 32'h1234_5678, 4'h3, 1'b1, 1'b0, 32'h0078, 1'b1};
    tbl[5]  = '{BaudA, 32'h0,         4'h0, 1'b0, 1'b1, 32'h5678, 1'b1};
    tbl[6]  = '{NoneA, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0,    1'b0};
    tbl[7]  = '{BaudA, 32'h0,         4'h0, 1'b0, 1'b1, 32'h5678, 1'b1};
    tbl[8]  = '{BaudA, 32'hAAAA_AAAA, 4'hC, 1'b1, 1'b0, 32'h5678, 1'b1};
    tbl[9]  = '{BaudA, 32'h0,         4'h0, 1'b0, 1'b1, 32'h5678, 1'b1};
    tbl[10] = '{DataA, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0,    1'b1};
    tbl[11] = '{StatA, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0,    1'b1};
    tbl[12] = '{Base + 32'h1, 32'h0,  4'h0, 1'b0, 1'b1, 32'h0,    1'b0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].we, tbl[i].re, 1'b0, 8'h0, rd, h);
      check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_hit", i), {31'b0, h}, {31'b0, tbl[i].exp_hit});
    end
    check("no_start_after_reset", starts, 0);

    // Two bytes, start latency and serialisation behind busy.
    s0 = starts;
    step(DataA, 32'h41, 4'h1, 1'b1, 1'b0, 1'b0, 8'h0, rd, h);
    check("start_lat_e0", {31'b0, tx_start}, 32'h0);
    step(DataA, 32'h42, 4'h1, 1'b1, 1'b0, 1'b0, 8'h0, rd, h);
    check("start_lat_e1", {31'b0, tx_start}, 32'h0);
    idle(1);
    check("start_lat_e2", {31'b0, tx_start}, 32'h1);
    drain("two_byte_drain");
    check("two_byte_starts", starts - s0, 2);
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
    check("two_byte_status", rd, 32'h0);

    // Fill TX with Uart held busy; 5th byte dropped; push while full at the pop edge.
    s0   = starts;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) step(DataA, 32'hA0 + i, 4'h1, 1'b1, 1'b0, 1'b0, 8'h0, rd, h);
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
    check("tx_full_status", rd, 32'h60);
    step(DataA, 32'hA4, 4'h1, 1'b1, 1'b0, 1'b0, 8'h0, rd, h);
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
    check("tx_full_after_drop", rd, 32'h60);
    hold = 1'b0;
    idle(1);
    step(DataA, 32'hA5, 4'h1, 1'b1, 1'b0, 1'b0, 8'h0, rd, h);
    drain("full_drain");
    check("full_starts", starts - s0, 5);

    // RX overrun and sticky clear.
    for (int i = 0; i < 5; i++) step(NoneA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h10 + i, rd, h);
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
    check("rx_ovr_status", rd, 32'h03);
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h0, rd, h);
    check("rx_ovr_preclear", rd, 32'h03);
    for (int i = 0; i < 4; i++) begin
      step(DataA, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h0, rd, h);
      check($sformatf("rx_pop%0d", i), rd, 32'h10 + i);
    end
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h0, rd, h);
    check("rx_status_cleared", rd, 32'h0);
    step(DataA, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h0, rd, h);
    check("rx_empty_read", rd, 32'h0);

    // RX full, push and pop in the same cycle.
    for (int i = 0; i < 4; i++) step(NoneA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h20 + i, rd, h);
    step(DataA, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 8'h24, rd, h);
    check("rx_full_pushpop_rd", rd, 32'h20);
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
    check("rx_full_pushpop_status", rd, 32'h01);
    for (int i = 0; i < 4; i++) begin
      step(DataA, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h0, rd, h);
      check($sformatf("rx_pp_pop%0d", i), rd, 32'h21 + i);
    end

    // Reset while bytes are queued flushes the TX FIFO.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step(DataA, 32'hC0 + i, 4'h1, 1'b1, 1'b0, 1'b0, 8'h0, rd, h);
    hold = 1'b0;
    do_reset();
    s0 = starts;
    idle(20);
    check("reset_flush_starts", starts - s0, 0);
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
    check("reset_flush_status", rd, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = DataA;
        2:       a = StatA;
        3:       a = BaudA;
        4:       a = NoneA;
        default: a = Base + $urandom_range(0, 511);
      endcase
      if ($urandom_range(0, 49) == 0) hold = ~hold;
      step(a, $urandom, 4'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, 8'($urandom), rd, h);
    end
    hold = 1'b0;
    drain("random_drain");
    step(StatA, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h0, rd, h);
    check("random_tx_idle", {25'b0, rd[6:0]} & 32'h60, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
